if_fetch: RTL and testbench

Instruction-fetch stage that produces the pc/instruction pair consumed by the IF/ID pipeline register and the decode stage.
- Fetches each 32-bit instruction as four little-endian byte reads over the byte-wide memory-controller port.
- Raises a stall request until a whole instruction is assembled.
- Applies the decode stage's next-pc redirect (use_npc/npc_addr), discarding any fetch in flight.

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/if_fetch.sv | 110 +++++++++++
 tb/tb_if_fetch.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction-fetch stage: bus widths, FSM state encoding
// and the byte-address helper.
package if_fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    typedef logic [ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_DONE  = 3'd2,
        S_FLUSH = 3'd3
    } if_state_e;

    function automatic inst_addr_t byte_addr(input inst_addr_t pc, input logic [1:0] cnt);
        return pc + inst_addr_t'(cnt);
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four little-endian
// byte reads and presents it to decode, honouring redirects and downstream stalls.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        pipe_stall,
    input  logic        use_npc,
    input  logic [31:0] npc_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        stall_req
);

    if_state_e  state_q, state_d;
    inst_addr_t pc_q, pc_d;
    logic [1:0] cnt_q, cnt_d;
    inst_t      inst_q, inst_d;
    logic       valid_q, valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        valid_d = valid_q;

        if (use_npc) begin
            pc_d    = npc_addr;
            cnt_d   = '0;
            valid_d = 1'b0;
            // A granted-but-unreturned byte must be drained before refetching
            unique case (state_q)
                S_REQ:   state_d = mem_gnt    ? S_FLUSH : S_REQ;
                S_WAIT:  state_d = mem_rvalid ? S_REQ   : S_FLUSH;
                S_FLUSH: state_d = mem_rvalid ? S_REQ   : S_FLUSH;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (mem_gnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        inst_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                        if (cnt_q == 2'd3) begin
                            state_d = S_DONE;
                            valid_d = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + 2'd1;
                            state_d = S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    if (!pipe_stall) begin
                        pc_d    = pc_q + 32'd4;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = S_REQ;
                    end
                end
                S_FLUSH: begin
                    if (mem_rvalid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Gated by rst so the request drops immediately on an asynchronous reset
    assign mem_req   = (state_q == S_REQ) && !rst;
    assign mem_addr  = mem_req ? byte_addr(pc_q, cnt_q) : '0;
    assign if_pc     = pc_q;
    assign if_inst   = inst_q;
    assign if_valid  = valid_q;
    assign stall_req = !valid_q;

    // A returned byte is only legal while one is outstanding
    assert property (@(posedge clk) disable iff (rst)
        !(rdy && mem_rvalid && (state_q == S_REQ || state_q == S_DONE)));

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte-wide memory responder with programmable delays,
// a vector table, directed redirect/reset sequences and a randomized stream check.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        ps = 1'b1;
    logic        use_npc = 1'b0;
    logic [31:0] npc = '0;

    logic        mem_req, gnt, rvalid, if_valid, stall_req;
    logic [31:0] mem_addr, if_pc, if_inst;
    logic [7:0]  rdata;

    logic        mem_req_b, gnt_b, rvalid_b, if_valid_b, stall_req_b;
    logic [31:0] mem_addr_b, if_pc_b, if_inst_b;
    logic [7:0]  rdata_b;

    logic [7:0]  mem [0:8191];
    int          total = 0;
    int          bad = 0;

    int unsigned g_lo = 0, g_hi = 0, rv_lo = 0, rv_hi = 0;
    int unsigned g_wait = 0, rv_wait = 0;
    logic        pend = 1'b0, pend_b = 1'b0;
    logic [31:0] paddr = '0, paddr_b = '0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pipe_stall(ps), .use_npc(use_npc), .npc_addr(npc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(gnt), .mem_rvalid(rvalid),
        .mem_rdata(rdata), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
        .stall_req(stall_req)
    );

    if_fetch #(.RESET_PC(32'h0000_0100)) dut_b (
        .clk(clk), .rst(rst), .rdy(rdy), .pipe_stall(ps), .use_npc(use_npc), .npc_addr(npc),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_gnt(gnt_b), .mem_rvalid(rvalid_b),
        .mem_rdata(rdata_b), .if_pc(if_pc_b), .if_inst(if_inst_b), .if_valid(if_valid_b),
        .stall_req(stall_req_b)
    );

    // Responder for dut: one outstanding byte, random grant / return delays
    assign gnt    = mem_req && rdy && !pend && (g_wait == 0);
    assign rvalid = pend && rdy && (rv_wait == 0);
    assign rdata  = mem[paddr[12:0]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            g_wait  <= 0;
            rv_wait <= 0;
        end else if (rdy) begin
            if (gnt) begin
                pend    <= 1'b1;
                paddr   <= mem_addr;
                rv_wait <= $urandom_range(rv_hi, rv_lo);
            end else if (rvalid) begin
                pend   <= 1'b0;
                g_wait <= $urandom_range(g_hi, g_lo);
            end else if (pend && rv_wait > 0) begin
                rv_wait <= rv_wait - 1;
            end else if (!pend && mem_req && g_wait > 0) begin
                g_wait <= g_wait - 1;
            end
        end
    end

    // Responder for dut_b: fixed one-cycle grant-to-data
    assign gnt_b    = mem_req_b && rdy && !pend_b;
    assign rvalid_b = pend_b && rdy;
    assign rdata_b  = mem[paddr_b[12:0]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_b <= 1'b0;
        end else if (rdy) begin
            if (gnt_b) begin
                pend_b  <= 1'b1;
                paddr_b <= mem_addr_b;
            end else if (rvalid_b) begin
                pend_b <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] t;
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            t = a + 32'(k);
            w[8*k +: 8] = mem[t[12:0]];
        end
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm, input int maxc);
        for (int n = 0; n < maxc && !if_valid; n++) @(negedge clk);
        chk(nm, 32'(if_valid), 32'd1);
    endtask

    task automatic hunt_addr(input string nm, input logic [31:0] off, input int maxc);
        bit found;
        found = 1'b0;
        for (int n = 0; n < maxc && !found; n++) begin
            @(negedge clk);
            if (mem_req && mem_addr == if_pc + off) found = 1'b1;
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    typedef struct {
        logic        rdy;
        logic        ps;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        chk_inst;
    } vec_t;

    vec_t        tbl [12];
    int          consumed;
    logic [31:0] exp_pc;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'((i * 37) ^ (i >> 7) ^ 8'h5A);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;

        for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'h4, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'h5, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h4, 1'b1, 32'h5, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'h6, 1'b0};

        // Reset state and first-instruction latency
        repeat (3) @(negedge clk);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd1);
        chk("rst_pc_b", if_pc_b, 32'h100);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                chk("lat_valid", 32'(if_valid), 32'd0);
                chk("lat_stall", 32'(stall_req), 32'd1);
            end else begin
                chk("first_valid", 32'(if_valid), 32'd1);
                chk("first_stall", 32'(stall_req), 32'd0);
                chk("first_pc", if_pc, 32'h0);
                chk("first_inst", if_inst, 32'h00A00513);
            end
        end

        // Stall hold, frozen rdy, consume and the following byte requests
        for (int i = 0; i < 12; i++) begin
            rdy = tbl[i].rdy;
            ps  = tbl[i].ps;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_req", i), 32'(mem_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
            if (tbl[i].chk_inst) chk($sformatf("tbl%0d_inst", i), if_inst, 32'h00A00513);
        end
        rdy = 1'b1;
        ps  = 1'b1;
        wait_valid("wait_pc4", 20);
        chk("pc4", if_pc, 32'h4);
        chk("inst4", if_inst, word_at(32'h4));
        ps = 1'b0;
        @(negedge clk);
        ps = 1'b1;
        wait_valid("wait_pc8", 20);
        chk("pc8", if_pc, 32'h8);

        // Redirect in the same edge as consume: target wins over pc+4
        ps = 1'b0; use_npc = 1'b1; npc = 32'h40;
        @(negedge clk);
        ps = 1'b1; use_npc = 1'b0;
        chk("redir_done_pc", if_pc, 32'h40);
        chk("redir_done_valid", 32'(if_valid), 32'd0);
        chk("redir_done_addr", mem_addr, 32'h40);
        wait_valid("wait_pc40", 20);
        chk("inst40", if_inst, word_at(32'h40));

        // Redirect while byte 2 is outstanding: byte is flushed, fetch restarts at target
        rv_lo = 2; rv_hi = 2;
        ps = 1'b0;
        @(negedge clk);
        ps = 1'b1;
        hunt_addr("hunt_b2", 32'd2, 40);
        @(negedge clk);
        use_npc = 1'b1; npc = 32'h1000;
        @(negedge clk);
        use_npc = 1'b0;
        chk("flush_req", 32'(mem_req), 32'd0);
        chk("flush_stall", 32'(stall_req), 32'd1);
        chk("flush_pc", if_pc, 32'h1000);
        for (int n = 0; n < 20 && !mem_req; n++) @(negedge clk);
        chk("flush_next_addr", mem_addr, 32'h1000);
        wait_valid("wait_1000", 40);
        chk("pc1000", if_pc, 32'h1000);
        chk("inst1000", if_inst, word_at(32'h1000));

        // Randomized delays, rdy, stalls and occasional redirects against the stream model
        g_lo = 0; g_hi = 5; rv_lo = 0; rv_hi = 5;
        exp_pc = 32'h1000;
        consumed = 0;
        for (int cyc = 0; cyc < 40000 && consumed < 200; cyc++) begin
            rdy     = ($urandom_range(3, 0) != 0);
            ps      = ($urandom_range(1, 0) == 1);
            use_npc = ($urandom_range(49, 0) == 0);
            npc     = $urandom_range(8191, 0);
            if (rdy && use_npc) begin
                exp_pc = npc;
            end else if (rdy && if_valid && !ps) begin
                chk("rand_pc", if_pc, exp_pc);
                chk("rand_inst", if_inst, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            @(negedge clk);
        end
        chk("rand_count", 32'(consumed), 32'd200);

        // Asynchronous reset during byte 1, restart from the overridden RESET_PC
        rdy = 1'b1; use_npc = 1'b0; ps = 1'b0;
        g_lo = 0; g_hi = 0; rv_lo = 0; rv_hi = 0;
        hunt_addr("hunt_b1", 32'd1, 200);
        ps = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_inst", if_inst, 32'h0);
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_stall", 32'(stall_req), 32'd1);
        chk("arst_pc_b", if_pc_b, 32'h100);
        chk("arst_req_b", 32'(mem_req_b), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_addr", mem_addr, 32'h0);
        chk("rel_req_b", 32'(mem_req_b), 32'd1);
        chk("rel_addr_b", mem_addr_b, 32'h100);
        for (int n = 0; n < 40 && !if_valid_b; n++) @(negedge clk);
        chk("b_valid", 32'(if_valid_b), 32'd1);
        chk("b_pc", if_pc_b, 32'h100);
        chk("b_inst", if_inst_b, word_at(32'h100));
        chk("re_valid", 32'(if_valid), 32'd1);
        chk("re_inst", if_inst, 32'h00A00513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
